// File: rtl/dds_pkg.sv
// Shared definitions for the DDS command arbiter.
//   - command codes understood by the DDS drivers
//   - bit layout of the 40-bit command word {sel, cmd, data}
//   - arbiter FSM state encoding
package dds_pkg;

    typedef enum logic [3:0] {
        CMD_INIT = 4'd0,
        CMD_CH   = 4'd1,
        CMD_FRQ  = 4'd2,
        CMD_PHS  = 4'd3,
        CMD_AMP  = 4'd4,
        CMD_MPD  = 4'd5,
        CMD_MTYP = 4'd6,
        CMD_STRM = 4'd7,
        CMD_PRF  = 4'd8,
        CMD_STPM = 4'd9
    } cmd_e;

    localparam int WORD_W   = 40;
    localparam int SEL_LSB  = 36;
    localparam int SEL_W    = 4;
    localparam int CMD_LSB  = 32;
    localparam int CMD_W    = 4;
    localparam int DATA_LSB = 0;
    localparam int DATA_W   = 32;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous show-ahead FIFO for one requester queue.
// The head word is always presented on dout_o straight from the storage
// registers, so a pop can consume it in the same cycle it is examined.
//   clk_i, reset_i : clock, synchronous active-high reset (empties the queue)
//   push_i, din_i  : write request and data (ignored while full)
//   pop_i          : consume the head word (ignored while empty)
//   dout_o         : head word
//   full_o/empty_o : occupancy flags
module cmd_fifo #(
    parameter int WIDTH = 40,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic             do_push, do_pop;

    assign full_o  = (count == (AW+1)'(DEPTH));
    assign empty_o = (count == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign dout_o  = mem[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= din_i;
    end

endmodule

// File: rtl/dds_cmd_arb.sv
// Arbitrates host and sequencer command queues onto the shared DDS driver bus.
// One command is in flight at a time: trigger it, wait for the driver to go
// busy (ready_i low), then wait for it to finish (ready_i high). Both waits
// are bounded; an expiry sets the sticky error flag and records the source.
//   clk_i, reset_i                  : clock, synchronous active-high reset
//   hreq_valid/ready/word           : host requester push interface
//   sreq_valid/ready/word           : sequencer requester push interface
//   sel_o, cmd_o, data_o, cmdtrig_o : command bus to the drivers
//   ready_i                         : selected driver idle
//   busy_o, err_o, err_src_o        : status
module dds_cmd_arb
    import dds_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int BUSY_TO    = 4,
    parameter int DONE_TO    = 255
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              hreq_valid_i,
    output logic              hreq_ready_o,
    input  logic [WORD_W-1:0] hreq_word_i,
    input  logic              sreq_valid_i,
    output logic              sreq_ready_o,
    input  logic [WORD_W-1:0] sreq_word_i,
    output logic [SEL_W-1:0]  sel_o,
    output logic [CMD_W-1:0]  cmd_o,
    output logic [DATA_W-1:0] data_o,
    output logic              cmdtrig_o,
    input  logic              ready_i,
    output logic              busy_o,
    output logic              err_o,
    output logic              err_src_o
);

    localparam logic [7:0] BUSY_LIM = 8'(BUSY_TO - 1);
    localparam logic [7:0] DONE_LIM = 8'(DONE_TO - 1);

    logic [WORD_W-1:0] h_word, s_word, pop_word;
    logic              h_full, h_empty, s_full, s_empty;
    logic              pop_h, pop_s, tmo;
    state_e            state, state_nxt;
    logic [7:0]        tmo_cnt;
    logic              prio_seq;   // 1: sequencer wins the next tie
    logic              src;        // requester of the in-flight command

    // Ready is forced low during reset so nothing slips into a queue being cleared.
    assign hreq_ready_o = !h_full && !reset_i;
    assign sreq_ready_o = !s_full && !reset_i;

    cmd_fifo #(.WIDTH(WORD_W), .DEPTH(FIFO_DEPTH)) u_hfifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push_i  (hreq_valid_i && hreq_ready_o),
        .din_i   (hreq_word_i),
        .pop_i   (pop_h),
        .dout_o  (h_word),
        .full_o  (h_full),
        .empty_o (h_empty)
    );

    cmd_fifo #(.WIDTH(WORD_W), .DEPTH(FIFO_DEPTH)) u_sfifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push_i  (sreq_valid_i && sreq_ready_o),
        .din_i   (sreq_word_i),
        .pop_i   (pop_s),
        .dout_o  (s_word),
        .full_o  (s_full),
        .empty_o (s_empty)
    );

    always_comb begin
        state_nxt = state;
        pop_h     = 1'b0;
        pop_s     = 1'b0;
        tmo       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!s_empty && (prio_seq || h_empty)) begin
                    pop_s     = 1'b1;
                    state_nxt = ST_ISSUE;
                end else if (!h_empty) begin
                    pop_h     = 1'b1;
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: state_nxt = ST_WAIT_BUSY;
            ST_WAIT_BUSY: begin
                // A busy indication on the last allowed cycle still counts.
                if (!ready_i) begin
                    state_nxt = ST_WAIT_DONE;
                end else if (tmo_cnt >= BUSY_LIM) begin
                    tmo       = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            ST_WAIT_DONE: begin
                if (ready_i) begin
                    state_nxt = ST_IDLE;
                end else if (tmo_cnt >= DONE_LIM) begin
                    tmo       = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign pop_word = pop_s ? s_word : h_word;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state     <= ST_IDLE;
            tmo_cnt   <= '0;
            sel_o     <= '0;
            cmd_o     <= '0;
            data_o    <= '0;
            prio_seq  <= 1'b1;
            src       <= 1'b0;
            err_o     <= 1'b0;
            err_src_o <= 1'b0;
        end else begin
            state <= state_nxt;
            // Every transition (including IDLE->ISSUE) restarts the count.
            if (state_nxt != state)   tmo_cnt <= '0;
            else if (tmo_cnt != 8'hFF) tmo_cnt <= tmo_cnt + 8'd1;
            // Bus fields only change on a pop, so sel_o keeps routing in IDLE.
            if (pop_h || pop_s) begin
                sel_o    <= pop_word[SEL_LSB +: SEL_W];
                cmd_o    <= pop_word[CMD_LSB +: CMD_W];
                data_o   <= pop_word[DATA_LSB +: DATA_W];
                src      <= pop_s;
                prio_seq <= pop_h;
            end
            if (tmo) begin
                err_o     <= 1'b1;
                err_src_o <= src;
            end
        end
    end

    assign cmdtrig_o = (state == ST_ISSUE);
    assign busy_o    = (state != ST_IDLE);

endmodule

// File: tb/tb_dds_cmd_arb.sv
module tb_dds_cmd_arb;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        hreq_valid_i, hreq_ready_o, sreq_valid_i, sreq_ready_o;
    logic [39:0] hreq_word_i, sreq_word_i;
    logic [3:0]  sel_o, cmd_o;
    logic [31:0] data_o;
    logic        cmdtrig_o, ready_i, busy_o, err_o, err_src_o;

    always #5 clk = ~clk;

    dds_cmd_arb dut (
        .clk_i(clk), .reset_i(reset_i),
        .hreq_valid_i(hreq_valid_i), .hreq_ready_o(hreq_ready_o), .hreq_word_i(hreq_word_i),
        .sreq_valid_i(sreq_valid_i), .sreq_ready_o(sreq_ready_o), .sreq_word_i(sreq_word_i),
        .sel_o(sel_o), .cmd_o(cmd_o), .data_o(data_o), .cmdtrig_o(cmdtrig_o),
        .ready_i(ready_i), .busy_o(busy_o), .err_o(err_o), .err_src_o(err_src_o)
    );

    int n_pass = 0, n_total = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    // Driver model: after a trigger wait drv_dly cycles, drop ready for drv_low cycles.
    logic drv_en = 1'b0;
    int   drv_dly = 1, drv_low = 1;
    initial begin
        ready_i = 1'b1;
        forever begin
            @(negedge clk);
            if (cmdtrig_o && drv_en) begin
                repeat (drv_dly) @(negedge clk);
                ready_i = 1'b0;
                repeat (drv_low) @(negedge clk);
                ready_i = 1'b1;
            end
        end
    end

    // Trigger log: cycle stamp and select value of every trigger.
    int         cyc = 0;
    int         trig_cyc[$];
    logic [3:0] trig_sel[$];
    initial forever begin
        @(negedge clk);
        cyc++;
        if (cmdtrig_o) begin
            trig_cyc.push_back(cyc);
            trig_sel.push_back(sel_o);
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic do_reset(input bit check);
        repeat (12) @(negedge clk);
        reset_i = 1'b1; hreq_valid_i = 1'b0; sreq_valid_i = 1'b0;
        @(negedge clk);
        if (check) begin
            chk("rst_outs", {sel_o, cmd_o, data_o, cmdtrig_o, busy_o, err_o, err_src_o}, 64'd0);
            chk("rst_ready", {hreq_ready_o, sreq_ready_o}, 64'd0);
        end
        reset_i = 1'b0;
        trig_cyc.delete();
        trig_sel.delete();
        @(negedge clk);
        if (check) chk("post_rst_ready", {hreq_ready_o, sreq_ready_o}, 64'b11);
    endtask

    typedef struct {
        logic        src;       // 0 host, 1 sequencer
        logic [39:0] word;
        int          dly, low;
        int          exp_busy;
        logic        exp_err, exp_src;
    } vec_t;

    vec_t vt[5];

    initial begin
        int n, cnt, unst, idx, acc5, rdy_bad, errs;
        bit acc_prev;
        logic [39:0] w;
        logic [39:0] hw[5];

        reset_i = 1'b1; hreq_valid_i = 1'b0; sreq_valid_i = 1'b0;
        hreq_word_i = '0; sreq_word_i = '0;

        vt[0] = '{1'b0, {4'd0,  4'd2, 32'h1234_5678}, 2, 10, 13, 1'b0, 1'b0};
        vt[1] = '{1'b1, {4'd5,  4'd7, 32'hDEAD_BEEF}, 1, 1,  3,  1'b0, 1'b0};
        vt[2] = '{1'b0, {4'd15, 4'd9, 32'hFFFF_FFFF}, 4, 3,  8,  1'b0, 1'b0};
        vt[3] = '{1'b0, {4'd3,  4'd4, 32'h0000_0001}, 5, 3,  5,  1'b1, 1'b0};
        vt[4] = '{1'b1, {4'd9,  4'd1, 32'h8000_0000}, 5, 3,  5,  1'b1, 1'b1};

        // ---- single-command vectors ----
        for (int v = 0; v < 5; v++) begin
            do_reset(v == 0);
            drv_en = 1'b1; drv_dly = vt[v].dly; drv_low = vt[v].low;
            w = vt[v].word;
            @(negedge clk);
            if (vt[v].src) begin sreq_valid_i = 1'b1; sreq_word_i = w; end
            else           begin hreq_valid_i = 1'b1; hreq_word_i = w; end
            @(negedge clk);
            hreq_valid_i = 1'b0; sreq_valid_i = 1'b0;
            n = 0;
            while (!cmdtrig_o && n < 50) begin @(negedge clk); n++; end
            chk($sformatf("v%0d_trig", v), cmdtrig_o, 1'b1);
            chk($sformatf("v%0d_bus", v), {sel_o, cmd_o, data_o}, w);
            cnt = 0; unst = 0;
            while (busy_o && cnt < 400) begin
                if ({sel_o, cmd_o, data_o} !== w) unst++;
                cnt++;
                @(negedge clk);
            end
            chk($sformatf("v%0d_busy_cycles", v), cnt, vt[v].exp_busy);
            chk($sformatf("v%0d_bus_stable", v), unst, 0);
            chk($sformatf("v%0d_sel_hold", v), sel_o, w[39:36]);
            chk($sformatf("v%0d_err", v), {err_o, err_src_o}, {vt[v].exp_err, vt[v].exp_src});
        end

        // ---- round-robin: 3 words each, pushed together ----
        do_reset(0);
        drv_en = 1'b1; drv_dly = 1; drv_low = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            sreq_valid_i = 1'b1; sreq_word_i = {4'(8 + i), 4'd3, 32'(i)};
            hreq_valid_i = 1'b1; hreq_word_i = {4'(1 + i), 4'd4, 32'(i)};
        end
        @(negedge clk);
        sreq_valid_i = 1'b0; hreq_valid_i = 1'b0;
        n = 0;
        while (trig_sel.size() < 6 && n < 200) begin @(negedge clk); n++; end
        chk("rr_count", trig_sel.size(), 6);
        if (trig_sel.size() >= 6) begin
            logic [3:0] exp_sel[6];
            exp_sel = '{4'd8, 4'd1, 4'd9, 4'd2, 4'd10, 4'd3};
            for (int i = 0; i < 6; i++) chk($sformatf("rr_order%0d", i), trig_sel[i], exp_sel[i]);
            for (int i = 1; i < 6; i++)
                chk($sformatf("rr_spacing%0d", i), trig_cyc[i] - trig_cyc[i-1], 4);
        end

        // ---- busy timeout: driver never responds ----
        do_reset(0);
        drv_en = 1'b0;
        @(negedge clk); hreq_valid_i = 1'b1; hreq_word_i = {4'd3, 4'd1, 32'h11};
        @(negedge clk); hreq_valid_i = 1'b0; sreq_valid_i = 1'b1; sreq_word_i = {4'd12, 4'd2, 32'h22};
        @(negedge clk); sreq_valid_i = 1'b0;
        chk("bto_trig_host", {cmdtrig_o, sel_o}, {1'b1, 4'd3});
        repeat (4) @(negedge clk);
        chk("bto_err_early", err_o, 1'b0);
        @(negedge clk);
        chk("bto_err_host", {err_o, err_src_o, busy_o}, 3'b100);
        @(negedge clk);
        chk("bto_next_issue", {cmdtrig_o, sel_o}, {1'b1, 4'd12});
        repeat (5) @(negedge clk);
        chk("bto_err_seq", {err_o, err_src_o, busy_o}, 3'b110);

        // ---- done timeout with host queue filling behind it ----
        do_reset(0);
        drv_en = 1'b0; ready_i = 1'b0;
        for (int i = 0; i < 5; i++) hw[i] = {4'(1 + i), 4'd5, 32'(100 + i)};
        @(negedge clk); sreq_valid_i = 1'b1; sreq_word_i = {4'd7, 4'd8, 32'h77};
        @(negedge clk); sreq_valid_i = 1'b0;
        @(negedge clk);
        chk("dto_trig", {cmdtrig_o, sel_o}, {1'b1, 4'd7});
        idx = 0; acc_prev = 1'b0; acc5 = -1; rdy_bad = 0;
        for (int off = 1; off <= 262; off++) begin
            @(negedge clk);
            if (acc_prev) begin
                if (idx == 4) acc5 = off - 1;
                idx++;
            end
            hreq_valid_i = (idx < 5);
            if (idx < 5) hreq_word_i = hw[idx];
            acc_prev = hreq_valid_i && hreq_ready_o;
            if (off == 5) chk("fifo_full_ready", {idx[3:0], hreq_ready_o}, {4'd4, 1'b0});
            if (off > 5 && off <= 257 && hreq_ready_o) rdy_bad++;
            if (off == 256) chk("dto_before", {err_o, busy_o}, 2'b01);
            if (off == 257) begin
                chk("dto_err", {err_o, err_src_o, busy_o}, 3'b110);
                ready_i = 1'b1; drv_en = 1'b1; drv_dly = 1; drv_low = 1;
            end
        end
        hreq_valid_i = 1'b0;
        chk("fifo_ready_low_while_full", rdy_bad, 0);
        chk("fifo_5th_accept_cycle", acc5, 258);
        n = 0;
        while (trig_sel.size() < 6 && n < 100) begin @(negedge clk); n++; end
        chk("dto_drain_count", trig_sel.size(), 6);
        if (trig_sel.size() >= 6)
            for (int i = 0; i < 5; i++) chk($sformatf("dto_drain%0d", i), trig_sel[i+1], hw[i][39:36]);

        // ---- reset during WAIT_DONE with two words queued ----
        do_reset(0);
        drv_en = 1'b0; ready_i = 1'b0;
        @(negedge clk); sreq_valid_i = 1'b1; sreq_word_i = {4'd6, 4'd3, 32'hABCD};
        @(negedge clk); sreq_valid_i = 1'b0;
        @(negedge clk); hreq_valid_i = 1'b1; hreq_word_i = {4'd2, 4'd2, 32'h1};
        @(negedge clk); hreq_word_i = {4'd4, 4'd2, 32'h2};
        @(negedge clk); hreq_valid_i = 1'b0;
        chk("mid_rst_state", {busy_o, sel_o}, {1'b1, 4'd6});
        reset_i = 1'b1;
        @(negedge clk);
        chk("mid_rst_outs", {sel_o, cmd_o, data_o, cmdtrig_o, busy_o, err_o, err_src_o}, 64'd0);
        chk("mid_rst_ready", {hreq_ready_o, sreq_ready_o}, 64'd0);
        reset_i = 1'b0; ready_i = 1'b1; drv_en = 1'b1;
        @(negedge clk);
        chk("mid_rst_ready_after", {hreq_ready_o, sreq_ready_o}, 64'b11);
        errs = 0;
        for (int i = 0; i < 20; i++) begin
            if (cmdtrig_o || busy_o) errs++;
            @(negedge clk);
        end
        chk("mid_rst_no_trig", errs, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dds_cmd_arb.md
DDS_CMD_ARB -- requirements
Module: dds_cmd_arb

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, SHALL set the entries per requester queue (power of 2, at least 2).
REQ-002 Parameter BUSY_TO, default 4, SHALL set the max cycles from trigger to ready_i low.
REQ-003 Parameter DONE_TO, default 255, SHALL set the max cycles ready_i may stay low.
REQ-004 clk_i  in  1  sole clock; reset is synchronous and active-high.
REQ-005 reset_i  in  1  synchronous active-high reset.
REQ-006 hreq_valid_i / hreq_ready_o  in/out  1/1  host requester handshake.
REQ-007 hreq_word_i  in  40  host command {sel[39:36], cmd[35:32], data[31:0]}.
REQ-008 sreq_valid_i / sreq_ready_o  in/out  1/1  sequencer requester handshake.
REQ-009 sreq_word_i  in  40  sequencer command, same format as hreq_word_i.
REQ-010 sel_o  out  4  card select to all DDS drivers.
REQ-011 cmd_o  out  4  command code to driver.
REQ-012 data_o  out  32  command data to driver.
REQ-013 cmdtrig_o  out  1  one-cycle command trigger.
REQ-014 ready_i  in  1  ready from the selected driver; high when idle.
REQ-015 busy_o  out  1  high whenever the FSM is not in IDLE.
REQ-016 err_o  out  1  sticky timeout flag; cleared only by reset_i.
REQ-017 err_src_o  out  1  requester of the last timed-out command (0 host, 1 sequencer).

Function
REQ-018 Each requester SHALL have its own FIFO_DEPTH FIFO; a word is accepted when valid and ready are both high in the same cycle; ready_o SHALL be low when the FIFO is full.
REQ-019 Accepting a word into a full FIFO SHALL be impossible; a simultaneous accept and pop on a full FIFO SHALL be allowed only through the pop, so ready_o stays low that cycle.
REQ-020 FSM states SHALL be IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
REQ-021 IDLE: when either FIFO is non-empty, the FSM SHALL pop one word and go to ISSUE.
REQ-022 If both FIFOs are non-empty in IDLE, arbitration SHALL be round-robin, starting from the requester not served last; after reset the sequencer wins first.
REQ-023 On pop, sel_o, cmd_o and data_o SHALL load from the word; they become valid in ISSUE.
REQ-024 ISSUE SHALL assert cmdtrig_o for exactly one cycle, then go to WAIT_BUSY.
REQ-025 WAIT_BUSY: ready_i low SHALL go to WAIT_DONE.
REQ-026 WAIT_BUSY: after BUSY_TO cycles without ready_i low, the FSM SHALL set err_o, set err_src_o, and go to IDLE.
REQ-027 WAIT_DONE: ready_i high SHALL go to IDLE.
REQ-028 WAIT_DONE: after DONE_TO cycles with ready_i still low, the FSM SHALL set err_o, set err_src_o, and go to IDLE.
REQ-029 The timeout counter SHALL be 8 bits, SHALL clear on every state entry, and SHALL saturate.
REQ-030 sel_o SHALL hold its last value in IDLE, never reverting to 0, so the selected driver keeps profile routing.
REQ-031 Minimum spacing between consecutive triggers SHALL be 4 cycles: ISSUE, WAIT_BUSY, WAIT_DONE, IDLE.
REQ-032 A new word SHALL never be popped in the same cycle ready_i returns high; the pop occurs in the following IDLE cycle.
REQ-033 The FSM SHALL never leave WAIT_BUSY or WAIT_DONE because a new request arrives; requests only queue.

Reset
REQ-034 On reset_i high at a clock edge, regardless of state, the block SHALL: go to IDLE; empty both FIFOs; drive sel_o=0, cmd_o=0, data_o=0, cmdtrig_o=0, busy_o=0, err_o=0, err_src_o=0; set the round-robin pointer to favour the sequencer.
REQ-035 Reset mid-transaction SHALL discard the in-flight command with no trigger; the driver is reset by the same reset_i.
REQ-036 hreq_ready_o and sreq_ready_o SHALL be 0 while reset_i is high and 1 in the first cycle after reset.

Structure
REQ-037 Shared package dds_pkg SHALL hold: command codes (INIT=0, CH=1, FRQ=2, PHS=3, AMP=4, MPD=5, MTYP=6, STRM=7, PRF=8, STPM=9); the command-word field offsets; the FSM state encoding.
REQ-038 A single sub-module, cmd_fifo (width 40, depth FIFO_DEPTH, synchronous, first-word registered output), SHALL be instantiated twice.

Verification
REQ-039 Host pushes {sel=0, cmd=2, data=0x1234_5678}; driver model drops ready for 10 cycles -> one cmdtrig_o pulse; sel_o=0, cmd_o=2, data_o=0x12345678 stable until IDLE; busy_o high for 13 cycles; err_o=0.
REQ-040 Both requesters push 3 words each in the same cycle -> trigger order S,H,S,H,S,H; triggers spaced at least 4 cycles apart.
REQ-041 Host pushes 5 words back-to-back with ready_i held low -> hreq_ready_o drops after 4 accepted words, and the 5th is accepted only after the first pop.
REQ-042 Driver model never drops ready_i -> err_o=1 and err_src_o set to the requester, 4 cycles after the trigger; the next queued command still issues.
REQ-043 ready_i stuck low -> err_o=1 after 255 WAIT_DONE cycles; FSM returns to IDLE.
REQ-044 reset_i asserted during WAIT_DONE with 2 words queued -> all outputs at reset values next cycle; no further triggers; FIFOs empty.
